ajuste_horario: RTL and testbench

AJUSTE_HORARIO -- requirements
Module: ajuste_horario

---
 rtl/ajuste_horario_pkg.sv | 63 ++++++
 rtl/ajuste_horario_debounce_btn.sv | 56 +++++
 rtl/ajuste_horario.sv | 148 ++++++++++++++
 tb/tb_ajuste_horario.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ajuste_horario_pkg.sv
// ajuste_horario_pkg
// Shared definitions for the time-setting block:
//   - FSM state encoding (IDLE, SET_H, SET_M, LOAD)
//   - edit_field display codes
//   - BCD limits for hours (23) and minutes (59)
//   - the BCD time bundle and its increment helpers
package ajuste_horario_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SET_H = 2'd1;
  localparam logic [1:0] ST_SET_M = 2'd2;
  localparam logic [1:0] ST_LOAD  = 2'd3;

  localparam logic [1:0] FIELD_NONE    = 2'b00;
  localparam logic [1:0] FIELD_HOURS   = 2'b01;
  localparam logic [1:0] FIELD_MINUTES = 2'b10;

  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;

  localparam logic [1:0] HOUR_MAX_TENS  = 2'(HOUR_MAX / 10);
  localparam logic [3:0] HOUR_MAX_UNITS = 4'(HOUR_MAX % 10);
  localparam logic [3:0] MIN_MAX_TENS   = 4'(MIN_MAX / 10);
  localparam logic [3:0] BCD_UNITS_MAX  = 4'd9;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } bcd_time_t;

  // Hours step: 09->10, 19->20, 23->00. Minutes are left untouched.
  function automatic bcd_time_t inc_hours(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.h1 == HOUR_MAX_TENS && t.h0 == HOUR_MAX_UNITS) begin
      r.h1 = 2'd0;
      r.h0 = 4'd0;
    end else if (t.h0 >= BCD_UNITS_MAX) begin
      r.h1 = t.h1 + 2'd1;
      r.h0 = 4'd0;
    end else begin
      r.h0 = t.h0 + 4'd1;
    end
    return r;
  endfunction

  // Minutes step: units wrap 9->0 carrying into tens, 59->00, never into hours.
  function automatic bcd_time_t inc_minutes(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.m0 >= BCD_UNITS_MAX) begin
      r.m0 = 4'd0;
      if (t.m1 >= MIN_MAX_TENS) r.m1 = 4'd0;
      else                      r.m1 = t.m1 + 4'd1;
    end else begin
      r.m0 = t.m0 + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ajuste_horario_debounce_btn.sv
// debounce_btn
// Conditions one raw asynchronous push-button:
//   2-FF synchronizer -> debouncer (new level accepted after DEB_CYCLES
//   consecutive differing samples) -> rising-edge press pulse.
// Ports:
//   clk    : clock
//   reset  : asynchronous active-low reset
//   btn    : raw button, active-high
//   level  : debounced button level
//   press  : one-cycle pulse on the first cycle level is high after being low
module debounce_btn #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic          level_dly_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg     <= 1'b0;
      sync2_reg     <= 1'b0;
      level_reg     <= 1'b0;
      level_dly_reg <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      sync1_reg     <= btn;
      sync2_reg     <= sync1_reg;
      level_dly_reg <= level_reg;
      // Count synchronized samples that disagree with the accepted level;
      // any agreeing sample restarts the run.
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(DEB_CYCLES - 1)) begin
        level_reg <= sync2_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign level = level_reg;
  assign press = level_reg & ~level_dly_reg;

endmodule

// File: rtl/ajuste_horario.sv
// ajuste_horario
// Two-button time-setting front end for a BCD clock core.
//   mode: IDLE -> SET_H (seeded from cur_*) -> SET_M -> LOAD -> IDLE
//   inc : steps the selected field, with auto-repeat while held.
// Ports:
//   clk, reset                 : clock, asynchronous active-low reset
//   btn_mode, btn_inc          : raw asynchronous push-buttons, active-high
//   cur_H1/H0/M1/M0            : current BCD time, sampled on entering SET_H
//   H_in1/H_in0/M_in1/M_in0    : edit registers (always visible)
//   LD_time                    : one-cycle load strobe in LOAD
//   editing, edit_field        : registered-state decode for the display
module ajuste_horario
  import ajuste_horario_pkg::*;
#(
  parameter int DEB_CYCLES     = 4,
  parameter int REP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [1:0] cur_H1,
  input  logic [3:0] cur_H0,
  input  logic [3:0] cur_M1,
  input  logic [3:0] cur_M0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       editing,
  output logic [1:0] edit_field
);

  localparam int RW = $clog2(REP_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          mode_level;
  logic          mode_press;
  logic          inc_level;
  logic          inc_press;
  logic          rep_fire;
  logic          inc_event;
  logic          any_event;
  logic          in_edit;
  logic          timeout_hit;
  logic [1:0]    state_reg;
  logic [RW-1:0] rep_cnt_reg;
  logic [TW-1:0] to_cnt_reg;
  bcd_time_t     time_reg;
  bcd_time_t     cur_time;

  debounce_btn #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_mode),
    .level (mode_level),
    .press (mode_press)
  );

  debounce_btn #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_inc),
    .level (inc_level),
    .press (inc_press)
  );

  // Phase counter since the inc press: it is 0 on the press cycle and wraps
  // every REP_CYCLES, so a wrap back to 0 marks press+REP, press+2*REP, ...
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_cnt_reg <= '0;
    end else if (!inc_level) begin
      rep_cnt_reg <= '0;
    end else if (rep_cnt_reg == RW'(REP_CYCLES - 1)) begin
      rep_cnt_reg <= '0;
    end else begin
      rep_cnt_reg <= rep_cnt_reg + RW'(1);
    end
  end

  // A repeat tick is dropped while mode is also held, so a two-button hold
  // cannot keep stepping a field the user is in the middle of leaving.
  assign rep_fire  = inc_level & ~inc_press & ~mode_level & (rep_cnt_reg == '0);
  assign inc_event = inc_press | rep_fire;
  assign any_event = mode_press | inc_event;

  assign in_edit     = (state_reg == ST_SET_H) || (state_reg == ST_SET_M);
  assign timeout_hit = (to_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) && !any_event;

  // Idle-cycle counter for the edit states; cleared by any event and outside edit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_reg <= '0;
    end else if (in_edit && !any_event && !timeout_hit) begin
      to_cnt_reg <= to_cnt_reg + TW'(1);
    end else begin
      to_cnt_reg <= '0;
    end
  end

  assign cur_time = {cur_H1, cur_H0, cur_M1, cur_M0};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      time_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (mode_press) begin
            time_reg  <= cur_time;
            state_reg <= ST_SET_H;
          end
        end
        ST_SET_H: begin
          // mode has priority; a coincident inc is discarded
          if (mode_press)       state_reg <= ST_SET_M;
          else if (inc_event)   time_reg  <= inc_hours(time_reg);
          else if (timeout_hit) state_reg <= ST_IDLE;
        end
        ST_SET_M: begin
          if (mode_press)       state_reg <= ST_LOAD;
          else if (inc_event)   time_reg  <= inc_minutes(time_reg);
          else if (timeout_hit) state_reg <= ST_IDLE;
        end
        ST_LOAD:  state_reg <= ST_IDLE;
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

  assign H_in1   = time_reg.h1;
  assign H_in0   = time_reg.h0;
  assign M_in1   = time_reg.m1;
  assign M_in0   = time_reg.m0;
  assign LD_time = (state_reg == ST_LOAD);
  assign editing = in_edit;

  always_comb begin
    edit_field = FIELD_NONE;
    if (state_reg == ST_SET_H)      edit_field = FIELD_HOURS;
    else if (state_reg == ST_SET_M) edit_field = FIELD_MINUTES;
  end

endmodule

// File: tb/tb_ajuste_horario.sv
module tb_ajuste_horario;

  localparam int DEB = 4;
  localparam int REP = 16;
  localparam int TOUT = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [1:0] cur_H1 = '0;
  logic [3:0] cur_H0 = '0, cur_M1 = '0, cur_M0 = '0;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time, editing;
  logic [1:0] edit_field;

  int n_cmp = 0;
  int n_bad = 0;

  int ld_count = 0;
  int ld_run = 0;
  int ld_max_run = 0;
  int cap_h = -1;
  int cap_m = -1;

  ajuste_horario #(.DEB_CYCLES(DEB), .REP_CYCLES(REP), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_H1(cur_H1), .cur_H0(cur_H0), .cur_M1(cur_M1), .cur_M0(cur_M0),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .editing(editing), .edit_field(edit_field)
  );

  always #5 clk = ~clk;

  // Load-strobe monitor: counts pulses, tracks longest run, captures time.
  always @(negedge clk) begin
    if (LD_time === 1'b1) begin
      ld_count <= ld_count + 1;
      ld_run   <= ld_run + 1;
      cap_h    <= int'(H_in1) * 10 + int'(H_in0);
      cap_m    <= int'(M_in1) * 10 + int'(M_in0);
    end else begin
      ld_run <= 0;
    end
    if (ld_run > ld_max_run) ld_max_run <= ld_run;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete (time limit)");
    $fatal(1, "watchdog");
  end

  function automatic int out_h();
    return int'(H_in1) * 10 + int'(H_in0);
  endfunction

  function automatic int out_m();
    return int'(M_in1) * 10 + int'(M_in0);
  endfunction

  // Events produced by a raw hold of n cycles: debounce swallows anything
  // shorter than DEB; otherwise the press plus one every REP cycles held.
  function automatic int hold_events(input int n);
    if (n < DEB) return 0;
    return 1 + (n - 1) / REP;
  endfunction

  task automatic set_cur(input int h, input int m);
    cur_H1 = 2'(h / 10);
    cur_H0 = 4'(h % 10);
    cur_M1 = 4'(m / 10);
    cur_M0 = 4'(m % 10);
  endtask

  task automatic press_mode();
    @(negedge clk) btn_mode = 1'b1;
    repeat (6) @(negedge clk);
    btn_mode = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic hold_inc(input int n);
    @(negedge clk) btn_inc = 1'b1;
    repeat (n) @(negedge clk);
    btn_inc = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic do_edit(input string name, input int h, input int m, input int nh, input int nm);
    int ld_before;
    int exp_h, exp_m;
    exp_h = (h + nh) % 24;
    exp_m = (m + nm) % 60;
    set_cur(h, m);
    press_mode();
    n_cmp++;
    if (edit_field !== 2'b01 || editing !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_enter_set_h: field=%b editing=%b required field=01 editing=1", name, edit_field, editing);
    end
    repeat (nh) hold_inc(6);
    press_mode();
    n_cmp++;
    if (edit_field !== 2'b10 || out_h() != exp_h) begin
      n_bad++;
      $display("FAIL %s_enter_set_m: field=%b hours=%0d required field=10 hours=%0d", name, edit_field, out_h(), exp_h);
    end
    repeat (nm) hold_inc(6);
    ld_before = ld_count;
    press_mode();
    repeat (4) @(negedge clk);
    n_cmp++;
    if (ld_count != ld_before + 1 || cap_h != exp_h || cap_m != exp_m || editing !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_load: pulses=%0d time=%0d:%0d editing=%b required pulses=1 time=%0d:%0d editing=0",
               name, ld_count - ld_before, cap_h, cap_m, editing, exp_h, exp_m);
    end
    $display("edit %s: seed %0d:%0d +%0dh +%0dm -> loaded %0d:%0d", name, h, m, nh, nm, cap_h, cap_m);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_cur(12, 34);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out_h() != 0 || out_m() != 0 || LD_time !== 1'b0 || editing !== 1'b0 || edit_field !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_state: time=%0d:%0d ld=%b editing=%b field=%b required 0:0 ld=0 editing=0 field=00",
               out_h(), out_m(), LD_time, editing, edit_field);
    end
    reset = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (out_h() != 0 || out_m() != 0 || editing !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle_wait: time=%0d:%0d editing=%b required 0:0 editing=0", out_h(), out_m(), editing);
    end
  endtask

  task automatic test_basic_edit();
    do_edit("basic_12_34", 12, 34, 3, 0);
  endtask

  task automatic test_bcd_limits();
    do_edit("hour_wrap", 23, 17, 1, 0);
    do_edit("min_wrap", 23, 59, 0, 1);
    do_edit("hour_09", 9, 5, 1, 0);
    do_edit("hour_19", 19, 49, 1, 11);
  endtask

  task automatic test_random_edit();
    for (int i = 0; i < 3; i++) begin
      do_edit("random", $urandom_range(23, 0), $urandom_range(59, 0),
              $urandom_range(25, 0), $urandom_range(61, 0));
    end
  endtask

  task automatic test_autorepeat();
    int h, m, n, ev;
    h = $urandom_range(23, 0);
    m = $urandom_range(59, 0);
    set_cur(h, m);
    press_mode();
    press_mode();
    hold_inc(2);
    n_cmp++;
    if (out_m() != m) begin
      n_bad++;
      $display("FAIL glitch_2cyc: minutes=%0d required %0d", out_m(), m);
    end
    hold_inc(40);
    m = (m + 3) % 60;
    n_cmp++;
    if (out_m() != m || out_h() != h) begin
      n_bad++;
      $display("FAIL hold_40cyc: time=%0d:%0d required %0d:%0d", out_h(), out_m(), h, m);
    end
    for (int i = 0; i < 4; i++) begin
      n = (i == 0) ? 3 : $urandom_range(60, 1);
      ev = hold_events(n);
      hold_inc(n);
      m = (m + ev) % 60;
      n_cmp++;
      if (out_m() != m || out_h() != h || editing !== 1'b1) begin
        n_bad++;
        $display("FAIL hold_%0dcyc: time=%0d:%0d editing=%b required %0d:%0d editing=1", n, out_h(), out_m(), editing, h, m);
      end
      $display("hold inc %0d cycles -> %0d events, minutes now %0d", n, ev, out_m());
    end
    press_mode();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_mode_inc_same_cycle();
    set_cur(7, 45);
    press_mode();
    @(negedge clk);
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    repeat (6) @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (8) @(negedge clk);
    n_cmp++;
    if (edit_field !== 2'b10 || out_h() != 7 || out_m() != 45) begin
      n_bad++;
      $display("FAIL mode_inc_collide: field=%b time=%0d:%0d required field=10 time=7:45", edit_field, out_h(), out_m());
    end
    press_mode();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_timeout();
    int ld_before;
    bit seen;
    ld_before = ld_count;
    set_cur(5, 20);
    seen = 0;
    @(negedge clk) btn_mode = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (editing === 1'b1) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL timeout_enter: editing never rose within 40 cycles, required 1");
    end
    repeat (TOUT - 2) @(negedge clk);
    btn_mode = 1'b0;
    n_cmp++;
    if (editing !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_early: editing=%b before %0d idle cycles, required 1", editing, TOUT);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (editing !== 1'b0 || edit_field !== 2'b00 || ld_count != ld_before) begin
      n_bad++;
      $display("FAIL timeout_abandon: editing=%b field=%b pulses=%0d required editing=0 field=00 pulses=0",
               editing, edit_field, ld_count - ld_before);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_in_load();
    bit seen;
    int ld_after;
    set_cur(18, 42);
    press_mode();
    press_mode();
    seen = 0;
    @(negedge clk) btn_mode = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (LD_time === 1'b1) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL reset_load_reach: LOAD never reached within 40 cycles");
    end
    reset = 1'b0;
    btn_mode = 1'b0;
    #1;
    n_cmp++;
    if (LD_time !== 1'b0 || out_h() != 0 || out_m() != 0 || editing !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_in_load: ld=%b time=%0d:%0d editing=%b required ld=0 time=0:0 editing=0",
               LD_time, out_h(), out_m(), editing);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    ld_after = ld_count;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (editing !== 1'b0 || edit_field !== 2'b00 || ld_count != ld_after || out_h() != 0 || out_m() != 0) begin
      n_bad++;
      $display("FAIL reset_release_idle: editing=%b field=%b pulses=%0d time=%0d:%0d required idle, no pulse, 0:0",
               editing, edit_field, ld_count - ld_after, out_h(), out_m());
    end
  endtask

  initial begin
    test_reset();
    test_basic_edit();
    test_bcd_limits();
    test_random_edit();
    test_autorepeat();
    test_mode_inc_same_cycle();
    test_timeout();
    test_reset_in_load();
    repeat (4) @(negedge clk);
    n_cmp++;
    if (ld_max_run != 1) begin
      n_bad++;
      $display("FAIL ld_width: longest LD_time run=%0d cycles, required 1", ld_max_run);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
